// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmitter and receiver: FSM state
// encoding, clocks-per-bit derivation and the even-parity rule.
`timescale 1ns/1ps
package uart_pkg;

    // 3-bit state encoding, kept identical on both sides of the link.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // Clocks per bit. TX and RX both use this, so the two ends divide identically.
    function automatic int calc_cpb(input int base_freq, input int baudrate);
        return base_freq / baudrate;
    endfunction

    // Even parity: the returned bit makes the total count of ones even.
    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake between a parallel producer and the UART transmitter.
// A byte moves on a rising edge where tx_valid && tx_ready.
`timescale 1ns/1ps
interface uart_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    // The producer drives data and valid. The transmitter answers with ready.
    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx.sv
// UART transmitter. Frame: 1 start bit, 8 data bits LSB first,
// 1 even-parity bit and STOP_BITS stop bits. Each bit lasts CPB clocks.
// All outputs are registered. The line idles high.
`timescale 1ns/1ps
module uart_tx
    import uart_pkg::*;
#(
    parameter int BASE_FREQ = 50_000_000,
    parameter int BAUDRATE  = 115_200,
    parameter int STOP_BITS = 1
) (
    input  logic     clk,
    input  logic     rst_n,
    uart_tx_if.slave tx_if,
    output logic     serial_out,
    output logic     busy,
    output logic     tx_done
);

    localparam int CPB   = calc_cpb(BASE_FREQ, BAUDRATE);
    localparam int CNT_W = (CPB > 1) ? $clog2(CPB) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CPB - 1);
    localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

    // Reject parameter sets that cannot produce a valid frame.
    if (CPB < 2) begin : g_bad_cpb
        $error("uart_tx: BASE_FREQ/BAUDRATE must give at least 2 clocks per bit");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end

    uart_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;      // clocks spent in the current bit
    logic [2:0]       bit_q, bit_d;      // data bit index, or stop bit index in STOP
    logic [7:0]       shreg_q, shreg_d;  // remaining data bits, current bit in [0]
    logic             par_q, par_d;      // parity of the latched byte
    logic             line_d, ready_d, busy_d, done_d;

    logic accept;
    logic cnt_last;

    assign accept   = tx_if.tx_valid && tx_if.tx_ready;
    assign cnt_last = (cnt_q == CNT_LAST);

    // Next-state, counter and shift logic. Registered outputs are decoded from the next state.
    always_comb begin
        // NOTE: every signal gets a default first, so no path through the case can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (accept) begin
                    state_d = ST_START;
                    shreg_d = tx_if.tx_data;
                    par_d   = even_parity(tx_if.tx_data);
                end
            end
            ST_START: begin
                if (cnt_last) begin
                    cnt_d   = '0;
                    state_d = ST_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (cnt_last) begin
                    cnt_d   = '0;
                    shreg_d = {1'b0, shreg_q[7:1]};
                    if (bit_q == 3'd7) begin
                        bit_d   = '0;
                        state_d = ST_PARITY;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_PARITY: begin
                if (cnt_last) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = ST_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (cnt_last) begin
                    cnt_d = '0;
                    if (bit_q == STOP_LAST) begin
                        bit_d   = '0;
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                bit_d   = '0;
            end
        endcase

        case (state_d)
            ST_START:  line_d = 1'b0;
            ST_DATA:   line_d = shreg_d[0];
            ST_PARITY: line_d = par_d;
            default:   line_d = 1'b1;
        endcase
        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE);
    end

    // State, datapath and registered outputs. Reset aborts any frame and forces the line high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            cnt_q           <= '0;
            bit_q           <= '0;
            // NOTE: the shift register is ordinary flops, not a RAM, so it is reset with the rest.
            shreg_q         <= '0;
            par_q           <= 1'b0;
            serial_out      <= 1'b1;
            tx_if.tx_ready  <= 1'b1;
            busy            <= 1'b0;
            tx_done         <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so every flop samples pre-edge values.
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            bit_q           <= bit_d;
            shreg_q         <= shreg_d;
            par_q           <= par_d;
            serial_out      <= line_d;
            tx_if.tx_ready  <= ready_d;
            busy            <= busy_d;
            tx_done         <= done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx with CPB = 16. One instance uses 1 stop bit
// and a second uses 2. A frame-level reference model predicts the line level
// for every cycle after a byte is accepted.
`timescale 1ns/1ps
module tb_uart_tx;

    localparam int BF  = 16;
    localparam int BR  = 1;
    localparam int CPB = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_tx_if if1 ();
    uart_tx_if if2 ();

    logic so1, b1, d1, so2, b2, d2;

    uart_tx #(.BASE_FREQ(BF), .BAUDRATE(BR), .STOP_BITS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .tx_if(if1), .serial_out(so1), .busy(b1), .tx_done(d1)
    );
    uart_tx #(.BASE_FREQ(BF), .BAUDRATE(BR), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .tx_if(if2), .serial_out(so2), .busy(b2), .tx_done(d2)
    );

    // The bench drives one instance at a time. sel picks it (0: 1 stop bit, 1: 2 stop bits).
    logic       sel = 1'b0;
    logic       drv_valid = 1'b0;
    logic [7:0] drv_data = 8'h00;

    assign if1.tx_valid = drv_valid & ~sel;
    assign if1.tx_data  = drv_data;
    assign if2.tx_valid = drv_valid & sel;
    assign if2.tx_data  = drv_data;

    logic obs_line, obs_ready, obs_busy, obs_done;
    assign obs_line  = sel ? so2 : so1;
    assign obs_ready = sel ? if2.tx_ready : if1.tx_ready;
    assign obs_busy  = sel ? b2 : b1;
    assign obs_done  = sel ? d2 : d1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: line level k cycles after acceptance (k = 1 is the first start-bit cycle).
    function automatic logic model_line(input logic [7:0] b, input int sb, input int k);
        int pos;
        if (k < 1 || k > (10 + sb) * CPB) return 1'b1;
        pos = (k - 1) / CPB;
        if (pos == 0) return 1'b0;
        if (pos <= 8) return b[pos-1];
        if (pos == 9) return ($countones(b) % 2) == 1;
        return 1'b1;
    endfunction

    // Wait up to a cycle budget for tx_ready. ok = 0 if the budget runs out.
    task automatic wait_ready(output bit ok);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!obs_ready && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        ok = obs_ready;
    endtask

    // Send one byte and compare the whole frame cycle by cycle against the model.
    task automatic run_frame(input logic [7:0] b, input int sb, input logic exp_par,
                             input int exp_done, input string tag, input logic which);
        logic samples [0:255];
        int   len, bad_line, bad_busy, ready_low, first_done, done_cnt, first_bad;
        bit   ok;
        logic [7:0] dec;
        sel = which;
        len = (10 + sb) * CPB;
        bad_line = 0; bad_busy = 0; ready_low = 0; first_done = 0; done_cnt = 0; first_bad = 0;
        wait_ready(ok);
        check({tag, " ready before send"}, int'(ok), 1);
        if (!ok) return;
        drv_data  = b;
        drv_valid = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= len + 1; k++) begin
            @(negedge clk);
            if (k == 1) begin
                drv_valid = 1'b0;
                drv_data  = 8'($urandom);
            end
            samples[k] = obs_line;
            if (obs_line !== model_line(b, sb, k)) begin
                bad_line++;
                if (first_bad == 0) first_bad = k;
            end
            if (obs_busy !== (k <= len)) bad_busy++;
            if (obs_ready !== 1'b1) ready_low++;
            if (obs_done === 1'b1) begin
                done_cnt++;
                if (first_done == 0) first_done = k;
            end
        end
        check({tag, " line mismatching cycles"}, bad_line, 0);
        if (bad_line != 0) $display("  first bad line cycle %0d", first_bad);
        check({tag, " busy mismatching cycles"}, bad_busy, 0);
        check({tag, " tx_ready low cycles"}, ready_low, len);
        check({tag, " tx_done cycle"}, first_done, exp_done);
        check({tag, " tx_done pulse count"}, done_cnt, 1);
        for (int i = 0; i < 8; i++) dec[i] = samples[CPB * (i + 1) + CPB / 2];
        check({tag, " decoded byte"}, int'(dec), int'(b));
        check({tag, " parity bit"}, int'(samples[CPB * 9 + CPB / 2]), int'(exp_par));
    endtask

    typedef struct {
        logic [7:0] data;
        int         stop_bits;
        logic       exp_par;
        int         exp_done;
    } vec_t;

    initial begin
        vec_t vecs [6];
        logic samples2 [0:399];
        logic done_s   [0:399];
        int   s1, s2;
        bit   ok;
        logic [7:0] dec;

        // Expected parity and tx_done cycle per vector, worked out from the frame rules.
        vecs[0] = '{8'h55, 1, 1'b0, 177};
        vecs[1] = '{8'h07, 1, 1'b1, 177};
        vecs[2] = '{8'h00, 1, 1'b0, 177};
        vecs[3] = '{8'hFF, 1, 1'b0, 177};
        vecs[4] = '{8'h81, 2, 1'b0, 193};
        vecs[5] = '{8'h96, 1, 1'b0, 177};

        // Reset values on both instances while rst_n is still low.
        #12;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            check($sformatf("reset%0d serial_out", s), int'(obs_line), 1);
            check($sformatf("reset%0d tx_ready", s), int'(obs_ready), 1);
            check($sformatf("reset%0d busy", s), int'(obs_busy), 0);
            check($sformatf("reset%0d tx_done", s), int'(obs_done), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Table of fixed bytes.
        for (int i = 0; i < 6; i++) begin
            run_frame(vecs[i].data, vecs[i].stop_bits, vecs[i].exp_par, vecs[i].exp_done,
                      $sformatf("vec%0d_%02h", i, vecs[i].data), vecs[i].stop_bits == 2);
        end

        // Back-to-back: hold tx_valid through 0xA5 then 0x3C. tx_data changes mid-frame.
        sel = 1'b0;
        wait_ready(ok);
        check("b2b ready", int'(ok), 1);
        drv_data  = 8'hA5;
        drv_valid = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 2 * 177 + 2; k++) begin
            @(negedge clk);
            if (k == 1)   drv_data  = 8'h3C;
            if (k == 178) drv_valid = 1'b0;
            samples2[k] = obs_line;
            done_s[k]   = obs_done;
        end
        s1 = 0;
        s2 = 0;
        for (int k = 1; k <= 2 * 177 + 2; k++) begin
            if (s1 == 0 && samples2[k] == 1'b0) s1 = k;
            if (s2 == 0 && k > 176 && samples2[k] == 1'b0) s2 = k;
        end
        check("b2b first start cycle", s1, 1);
        check("b2b start spacing", s2 - s1, 177);
        check("b2b done with next accept", int'(done_s[177]), 1);
        for (int i = 0; i < 8; i++) dec[i] = samples2[s1 - 1 + CPB * (i + 1) + CPB / 2];
        check("b2b frame1 byte", int'(dec), 8'hA5);
        check("b2b frame1 parity", int'(samples2[s1 - 1 + CPB * 9 + CPB / 2]), 0);
        for (int i = 0; i < 8; i++) dec[i] = samples2[s2 - 1 + CPB * (i + 1) + CPB / 2];
        check("b2b frame2 byte", int'(dec), 8'h3C);
        check("b2b frame2 parity", int'(samples2[s2 - 1 + CPB * 9 + CPB / 2]), 0);

        // Abort 0x96 frames with an asynchronous reset, at cycle 50 and at cycle 20 (line low there).
        foreach (vecs[i]) begin
            int at;
            if (i > 1) break;
            at = (i == 0) ? 50 : 20;
            sel = 1'b0;
            wait_ready(ok);
            check($sformatf("abort@%0d ready", at), int'(ok), 1);
            drv_data  = 8'h96;
            drv_valid = 1'b1;
            @(posedge clk);
            for (int k = 1; k <= at; k++) begin
                @(negedge clk);
                if (k == 1) drv_valid = 1'b0;
            end
            check($sformatf("abort@%0d line before", at), int'(obs_line),
                  int'(model_line(8'h96, 1, at)));
            #1 rst_n = 1'b0;
            #1;
            check($sformatf("abort@%0d serial_out", at), int'(obs_line), 1);
            check($sformatf("abort@%0d tx_ready", at), int'(obs_ready), 1);
            check($sformatf("abort@%0d busy", at), int'(obs_busy), 0);
            @(negedge clk);
            rst_n = 1'b1;
            run_frame(8'h96, 1, 1'b0, 177, $sformatf("after_abort@%0d", at), 1'b0);
        end

        // Random bytes on randomly chosen instances, separated by random idle gaps.
        for (int n = 0; n < 10; n++) begin
            logic [7:0] b;
            int sb;
            b  = 8'($urandom);
            sb = int'($urandom_range(1, 2));
            repeat ($urandom_range(0, 5)) @(negedge clk);
            run_frame(b, sb, logic'($countones(b) % 2), (10 + sb) * CPB + 1,
                      $sformatf("rand%0d_%02h_sb%0d", n, b, sb), sb == 2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
Serial transmitter that produces the framed UART stream consumed by the team's receiver: 1 start bit, 8 data bits LSB-first, 1 even-parity bit, STOP_BITS stop bits.
It accepts bytes from a parallel producer through a valid/ready handshake and drives one serial line.
Bit timing is derived from the same BASE_FREQ/BAUDRATE division as the receiver, so the pair interoperates with identical parameters.

Parameters:
BASE_FREQ, 50_000_000, system clock frequency in Hz
BAUDRATE, 115_200, line rate in bit/s; CPB = BASE_FREQ/BAUDRATE clock cycles per bit (434 at defaults); CPB >= 2 is required, elaboration error otherwise
STOP_BITS, 1, number of stop bits, legal values 1 or 2

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  one clock; reset is asynchronous and active-low
tx_data  input  8  byte to send, sampled only on handshake
tx_valid  input  1  producer has a byte on tx_data
tx_ready  output  1  block can accept a byte this cycle
serial_out  output  1  UART line, idles high
busy  output  1  frame in progress (state != IDLE)
tx_done  output  1  one-cycle pulse when the last stop bit completes

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, serial_out=1, tx_ready=1, busy=0, tx_done=0, bit counter=0, cycle counter=0, shift register=0.
- Reset asserted mid-frame aborts the frame immediately; the line returns high with no partial stop or parity bit.
- All outputs are registered. tx_ready = (state==IDLE).
- Handshake: a byte is accepted on a rising edge where tx_valid && tx_ready.
  - On acceptance, tx_data is latched and parity = XOR of its 8 bits, so the total count of ones over data+parity is even.
  - tx_valid while not ready is ignored and not consumed; tx_data changes after acceptance do not affect the frame.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on acceptance. serial_out=0 from the next cycle (1 cycle latency).
  - START: holds 0 for CPB cycles -> DATA.
  - DATA: bit i (i=0..7, LSB first) held CPB cycles each. After bit 7 -> PARITY.
  - PARITY: holds the parity bit for CPB cycles -> STOP.
  - STOP: holds 1 for STOP_BITS*CPB cycles -> IDLE. tx_done=1 in the first IDLE cycle only.
- Cycle counter runs 0..CPB-1 and is $clog2(CPB) bits wide; the bit advances when the counter reaches CPB-1. Bit index is 3 bits.
- Back-to-back: with tx_valid held high, IDLE lasts exactly 1 cycle (line high), so the frame period is (10+STOP_BITS)*CPB + 1 cycles.
- tx_done and acceptance of the next byte can occur in the same cycle.
- busy=1 from the cycle after acceptance through the last stop cycle.
- Unreachable state encodings go to IDLE with serial_out=1.

Decomposition:
- Shared package uart_pkg holds:
  - state encodings (3-bit IDLE/START/DATA/PARITY/STOP), shared with the receiver;
  - CPB computation as a constant function of BASE_FREQ/BAUDRATE;
  - even-parity function over 8 bits.
- No sub-module: the baud counter and shift register stay inline. A separate uart_baud_gen is not justified at this size.

Test Plan:
- Use BASE_FREQ=16, BAUDRATE=1 (CPB=16) unless stated.
- Send 0x55 -> line reads 0,1,0,1,0,1,0,1,0 | parity 0 | stop 1, each level exactly 16 cycles. tx_done pulses once at cycle 177 after acceptance. tx_ready low for 176 cycles.
- Send 0x07 (3 ones) -> parity bit 1. Send 0x00 -> parity 0. Send 0xFF -> parity 0.
- Hold tx_valid with 0xA5 then 0x3C -> second start bit falls exactly 177 cycles after the first. Both frames decode correctly. tx_data changed mid-frame does not alter the first frame.
- Assert rst_n low at cycle 50 of a 0x96 frame -> serial_out=1 the same cycle (asynchronous), tx_ready=1, busy=0. A new byte is accepted after release and its frame is correct.
- STOP_BITS=2, send 0x81 -> line high for 32 cycles after parity; tx_done at cycle 193.
- Loopback into uart_rx (same BASE_FREQ/BAUDRATE, its active-high reset driven by ~rst_n): send 0x96 -> receiver parallel_out=0x96 with no parity error.
